// File: rtl/shift_register_param_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : shift_register_param_if
// Brief    : Control, data and status bundle for shift_register_param.
// Revision : 1.0
// ============================================================================
interface shift_register_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       io_in;
    logic                   io_enable;
    logic [1:0]             io_mode;
    logic [WIDTH*DEPTH-1:0] io_load;
    logic [SEL_W-1:0]       io_tap_sel;
    logic [WIDTH-1:0]       io_out;
    logic [WIDTH-1:0]       io_tap;
    logic [CNT_W-1:0]       io_fill;
    logic                   io_full;

    modport master (
        output io_in, io_enable, io_mode, io_load, io_tap_sel,
        input  io_out, io_tap, io_fill, io_full
    );

    modport slave (
        input  io_in, io_enable, io_mode, io_load, io_tap_sel,
        output io_out, io_tap, io_fill, io_full
    );
endinterface
`default_nettype wire

// File: rtl/shift_register_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : shift_register_param
// Brief    : DEPTH-stage WIDTH-bit word shifter with shift/rotate/load/clear,
//            tap readout and saturating fill tracking.
// Revision : 1.0
// ============================================================================
module shift_register_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_register_param_if.slave bus
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0]       c_MODE_SHIFT  = 2'b00;
    localparam logic [1:0]       c_MODE_ROTATE = 2'b01;
    localparam logic [1:0]       c_MODE_LOAD   = 2'b10;
    localparam logic [1:0]       c_MODE_CLEAR  = 2'b11;
    localparam logic [CNT_W-1:0] c_FILL_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_FILL_ONE    = CNT_W'(1);

    logic [WIDTH-1:0] r_stage      [DEPTH];
    logic [WIDTH-1:0] w_stage_next [DEPTH];
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] w_fill_next;
    logic [WIDTH-1:0] w_tap;

    always_comb begin
        w_stage_next = r_stage;
        w_fill_next  = r_fill;
        case (bus.io_mode)
            c_MODE_SHIFT: begin
                w_stage_next[0] = bus.io_in;
                for (int i = 1; i < DEPTH; i++) begin
                    w_stage_next[i] = r_stage[i-1];
                end
                // Fill saturates at DEPTH rather than wrapping
                if (r_fill != c_FILL_FULL) begin
                    w_fill_next = r_fill + c_FILL_ONE;
                end
            end
            c_MODE_ROTATE: begin
                w_stage_next[0] = r_stage[DEPTH-1];
                for (int i = 1; i < DEPTH; i++) begin
                    w_stage_next[i] = r_stage[i-1];
                end
            end
            c_MODE_LOAD: begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_stage_next[i] = bus.io_load[i*WIDTH +: WIDTH];
                end
                w_fill_next = c_FILL_FULL;
            end
            c_MODE_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_stage_next[i] = '0;
                end
                w_fill_next = '0;
            end
            default: begin
                w_fill_next = r_fill;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_fill <= '0;
        end else if (bus.io_enable) begin
            r_stage <= w_stage_next;
            r_fill  <= w_fill_next;
        end
    end

    generate
        if (DEPTH == 1) begin : g_tap_single
            // Only one stage exists, so the select has nothing to choose
            logic w_unused_sel;
            assign w_unused_sel = ^bus.io_tap_sel;
            assign w_tap        = r_stage[0];
        end else begin : g_tap_mux
            // Selects past the last stage fall through to zero
            always_comb begin
                w_tap = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.io_tap_sel == SEL_W'(i)) begin
                        w_tap = r_stage[i];
                    end
                end
            end
        end
    endgenerate

    assign bus.io_out  = r_stage[DEPTH-1];
    assign bus.io_tap  = w_tap;
    assign bus.io_fill = r_fill;
    assign bus.io_full = (r_fill == c_FILL_FULL);

endmodule
`default_nettype wire

// File: tb/tb_shift_register_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_shift_register_param
// Brief    : Vector table, corner sequences and queue-model random run.
// Revision : 1.0
// ============================================================================
module tb_shift_register_param;
    logic clk;
    logic reset;

    shift_register_param_if #(.WIDTH(8),  .DEPTH(4)) bus_a ();
    shift_register_param_if #(.WIDTH(8),  .DEPTH(3)) bus_b ();
    shift_register_param_if #(.WIDTH(16), .DEPTH(1)) bus_c ();

    shift_register_param #(.WIDTH(8),  .DEPTH(4)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    shift_register_param #(.WIDTH(8),  .DEPTH(3)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    shift_register_param #(.WIDTH(16), .DEPTH(1)) u_dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [7:0]  din;
        logic [31:0] load;
        logic [1:0]  sel;
        logic [7:0]  out;
        logic [7:0]  tap;
        logic [2:0]  fill;
        logic        full;
    } vec_t;

    typedef logic [7:0] wq_t[$];

    vec_t vecs[$];
    wq_t  qa;
    wq_t  qb;
    int   fa;
    int   fb;

    logic        en_a, en_b;
    logic [1:0]  md_a, md_b;
    logic [7:0]  di_a, di_b;
    logic [31:0] ld_a, ld_b;
    logic [1:0]  sl_a, sl_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(logic en, logic [1:0] mode, logic [7:0] din, logic [31:0] load,
                               logic [1:0] sel, logic [7:0] out, logic [7:0] tap,
                               logic [2:0] fill, logic full);
        vec_t r;
        r.en = en; r.mode = mode; r.din = din; r.load = load; r.sel = sel;
        r.out = out; r.tap = tap; r.fill = fill; r.full = full;
        return r;
    endfunction

    // Reference: queue element k is stage k
    function automatic wq_t model_next(wq_t q, int d, logic [1:0] mode, logic [7:0] din, logic [31:0] load);
        wq_t r;
        r = q;
        case (mode)
            2'b00: begin r.push_front(din);    r = r[0:d-1]; end
            2'b01: begin r.push_front(q[d-1]); r = r[0:d-1]; end
            2'b10: begin r.delete(); for (int i = 0; i < d; i++) r.push_back(load[i*8 +: 8]); end
            default: begin r.delete(); for (int i = 0; i < d; i++) r.push_back(8'h00); end
        endcase
        return r;
    endfunction

    function automatic int fill_next(int f, int d, logic [1:0] mode);
        case (mode)
            2'b00:   return (f < d) ? f + 1 : f;
            2'b01:   return f;
            2'b10:   return d;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] tap_of(wq_t q, int d, int sel);
        return (sel < d) ? q[sel] : 8'h00;
    endfunction

    function automatic logic [1:0] pick_mode(int r);
        if (r < 5) return 2'b00;
        if (r < 7) return 2'b01;
        if (r < 9) return 2'b10;
        return 2'b11;
    endfunction

    task automatic idle_all();
        bus_a.io_enable = 1'b0; bus_a.io_mode = 2'b00; bus_a.io_in = '0; bus_a.io_load = '0; bus_a.io_tap_sel = '0;
        bus_b.io_enable = 1'b0; bus_b.io_mode = 2'b00; bus_b.io_in = '0; bus_b.io_load = '0; bus_b.io_tap_sel = '0;
        bus_c.io_enable = 1'b0; bus_c.io_mode = 2'b00; bus_c.io_in = '0; bus_c.io_load = '0; bus_c.io_tap_sel = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // en, mode, in, load, sel | out, tap, fill, full
        vecs.push_back(v(1, 2'b00, 8'h11, 32'h0,        2'd0, 8'h00, 8'h11, 3'd1, 0));
        vecs.push_back(v(1, 2'b00, 8'h22, 32'h0,        2'd1, 8'h00, 8'h11, 3'd2, 0));
        vecs.push_back(v(1, 2'b00, 8'h33, 32'h0,        2'd2, 8'h00, 8'h11, 3'd3, 0));
        vecs.push_back(v(1, 2'b00, 8'h44, 32'h0,        2'd3, 8'h11, 8'h11, 3'd4, 1));
        vecs.push_back(v(1, 2'b00, 8'h55, 32'h0,        2'd0, 8'h22, 8'h55, 3'd4, 1));
        vecs.push_back(v(1, 2'b10, 8'h00, 32'h44332211, 2'd0, 8'h44, 8'h11, 3'd4, 1));
        vecs.push_back(v(1, 2'b01, 8'hEE, 32'h0,        2'd0, 8'h33, 8'h44, 3'd4, 1));
        vecs.push_back(v(1, 2'b01, 8'hEE, 32'h0,        2'd1, 8'h22, 8'h44, 3'd4, 1));
        vecs.push_back(v(1, 2'b01, 8'hEE, 32'h0,        2'd2, 8'h11, 8'h44, 3'd4, 1));
        vecs.push_back(v(1, 2'b01, 8'hEE, 32'h0,        2'd3, 8'h44, 8'h44, 3'd4, 1));
        vecs.push_back(v(0, 2'b11, 8'hFF, 32'h0,        2'd0, 8'h44, 8'h11, 3'd4, 1));
        vecs.push_back(v(0, 2'b00, 8'hFF, 32'h0,        2'd1, 8'h44, 8'h22, 3'd4, 1));
        vecs.push_back(v(0, 2'b10, 8'hFF, 32'hFFFFFFFF, 2'd2, 8'h44, 8'h33, 3'd4, 1));
        vecs.push_back(v(0, 2'b01, 8'hFF, 32'h0,        2'd3, 8'h44, 8'h44, 3'd4, 1));
        vecs.push_back(v(1, 2'b11, 8'hFF, 32'h0,        2'd0, 8'h00, 8'h00, 3'd0, 0));
        vecs.push_back(v(1, 2'b00, 8'hAA, 32'h0,        2'd0, 8'h00, 8'hAA, 3'd1, 0));
        vecs.push_back(v(0, 2'b00, 8'hBB, 32'h0,        2'd0, 8'h00, 8'hAA, 3'd1, 0));
        vecs.push_back(v(0, 2'b00, 8'hCC, 32'h0,        2'd0, 8'h00, 8'hAA, 3'd1, 0));
        vecs.push_back(v(1, 2'b00, 8'h01, 32'h0,        2'd1, 8'h00, 8'hAA, 3'd2, 0));
        vecs.push_back(v(1, 2'b00, 8'h02, 32'h0,        2'd2, 8'h00, 8'hAA, 3'd3, 0));
        vecs.push_back(v(1, 2'b00, 8'h03, 32'h0,        2'd3, 8'hAA, 8'hAA, 3'd4, 1));

        idle_all();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        check("rst out",    bus_a.io_out,  8'h00);
        check("rst tap",    bus_a.io_tap,  8'h00);
        check("rst fill",   bus_a.io_fill, 3'd0);
        check("rst full",   bus_a.io_full, 1'b0);
        check("rst c out",  bus_c.io_out,  16'h0000);
        check("rst c full", bus_c.io_full, 1'b0);
        reset = 1'b1;

        foreach (vecs[k]) begin
            bus_a.io_enable  = vecs[k].en;
            bus_a.io_mode    = vecs[k].mode;
            bus_a.io_in      = vecs[k].din;
            bus_a.io_load    = vecs[k].load;
            bus_a.io_tap_sel = vecs[k].sel;
            tick();
            check($sformatf("vec%0d out",  k), bus_a.io_out,  vecs[k].out);
            check($sformatf("vec%0d tap",  k), bus_a.io_tap,  vecs[k].tap);
            check($sformatf("vec%0d fill", k), bus_a.io_fill, vecs[k].fill);
            check($sformatf("vec%0d full", k), bus_a.io_full, vecs[k].full);
        end

        // Clear while full: every tap must read zero
        bus_a.io_enable = 1'b1; bus_a.io_mode = 2'b11;
        tick();
        bus_a.io_enable = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus_a.io_tap_sel = 2'(s);
            #1;
            check($sformatf("clr tap%0d", s), bus_a.io_tap, 8'h00);
        end
        check("clr fill", bus_a.io_fill, 3'd0);
        check("clr full", bus_a.io_full, 1'b0);

        // Asynchronous reset between edges
        bus_a.io_enable = 1'b1; bus_a.io_mode = 2'b10; bus_a.io_load = 32'h44332211; bus_a.io_tap_sel = 2'd0;
        tick();
        check("pre-arst out", bus_a.io_out, 8'h44);
        bus_a.io_mode = 2'b00; bus_a.io_in = 8'h77;
        #3 reset = 1'b0;
        #1;
        check("arst out",  bus_a.io_out,  8'h00);
        check("arst tap",  bus_a.io_tap,  8'h00);
        check("arst fill", bus_a.io_fill, 3'd0);
        check("arst full", bus_a.io_full, 1'b0);
        bus_a.io_enable = 1'b0;
        #1 reset = 1'b1;
        tick();

        // DEPTH=3: select past the last stage reads zero
        bus_b.io_enable = 1'b1; bus_b.io_mode = 2'b10; bus_b.io_load = 24'h332211;
        tick();
        bus_b.io_enable = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus_b.io_tap_sel = 2'(s);
            #1;
            check($sformatf("d3 tap%0d", s), bus_b.io_tap, (s < 3) ? 8'(8'h11 * (s + 1)) : 8'h00);
        end
        check("d3 out",  bus_b.io_out,  8'h33);
        check("d3 fill", bus_b.io_fill, 2'd3);
        check("d3 full", bus_b.io_full, 1'b1);

        // DEPTH=1, WIDTH=16
        bus_c.io_enable = 1'b1; bus_c.io_mode = 2'b00; bus_c.io_in = 16'hBEEF;
        tick();
        check("d1 shift out",  bus_c.io_out,  16'hBEEF);
        check("d1 shift full", bus_c.io_full, 1'b1);
        check("d1 shift fill", bus_c.io_fill, 1'b1);
        bus_c.io_mode = 2'b01; bus_c.io_in = 16'h1234;
        tick();
        check("d1 rot out",  bus_c.io_out,  16'hBEEF);
        check("d1 rot fill", bus_c.io_fill, 1'b1);
        bus_c.io_enable = 1'b0; bus_c.io_tap_sel = 1'b1;
        #1;
        check("d1 tap", bus_c.io_tap, 16'hBEEF);

        // Random run on DEPTH=4 and DEPTH=3 against the queue model
        reset = 1'b0;
        #2 reset = 1'b1;
        qa = '{8'h00, 8'h00, 8'h00, 8'h00};
        qb = '{8'h00, 8'h00, 8'h00};
        fa = 0;
        fb = 0;
        for (int n = 0; n < 400; n++) begin
            en_a = ($urandom_range(0, 3) != 0);
            en_b = ($urandom_range(0, 3) != 0);
            md_a = pick_mode(int'($urandom_range(0, 9)));
            md_b = pick_mode(int'($urandom_range(0, 9)));
            di_a = 8'($urandom); di_b = 8'($urandom);
            ld_a = $urandom;     ld_b = $urandom;
            sl_a = 2'($urandom_range(0, 3));
            sl_b = 2'($urandom_range(0, 3));
            bus_a.io_enable = en_a; bus_a.io_mode = md_a; bus_a.io_in = di_a; bus_a.io_load = ld_a; bus_a.io_tap_sel = sl_a;
            bus_b.io_enable = en_b; bus_b.io_mode = md_b; bus_b.io_in = di_b; bus_b.io_load = ld_b[23:0]; bus_b.io_tap_sel = sl_b;
            tick();
            if (en_a) begin
                qa = model_next(qa, 4, md_a, di_a, ld_a);
                fa = fill_next(fa, 4, md_a);
            end
            if (en_b) begin
                qb = model_next(qb, 3, md_b, di_b, ld_b);
                fb = fill_next(fb, 3, md_b);
            end
            check($sformatf("rnd%0d a out",  n), bus_a.io_out,  qa[3]);
            check($sformatf("rnd%0d a tap",  n), bus_a.io_tap,  tap_of(qa, 4, int'(sl_a)));
            check($sformatf("rnd%0d a fill", n), bus_a.io_fill, 32'(fa));
            check($sformatf("rnd%0d a full", n), bus_a.io_full, 32'(fa == 4));
            check($sformatf("rnd%0d b out",  n), bus_b.io_out,  qb[2]);
            check($sformatf("rnd%0d b tap",  n), bus_b.io_tap,  tap_of(qb, 3, int'(sl_b)));
            check($sformatf("rnd%0d b fill", n), bus_b.io_fill, 32'(fb));
            check($sformatf("rnd%0d b full", n), bus_b.io_full, 32'(fb == 3));
            if (n % 97 == 50) begin
                reset = 1'b0;
                #2 reset = 1'b1;
                qa = '{8'h00, 8'h00, 8'h00, 8'h00};
                qb = '{8'h00, 8'h00, 8'h00};
                fa = 0;
                fb = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
Parametrised multi-stage word shift register, successor to the fixed 8-bit shifter. It carries WIDTH-bit words through DEPTH register stages. It adds four operating modes (shift, rotate, parallel load, clear), a selectable tap readout and fill/full tracking. It is used as a configurable delay line and small serial-to-parallel buffer in datapath test structures.

Parameters:
WIDTH, 8, bits per word/stage (>=1)
DEPTH, 4, number of stages (>=1)
SEL_W, max(1,clog2(DEPTH)), tap-select width (derived, not overridden)
CNT_W, clog2(DEPTH+1), fill-count width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
io_in  input  WIDTH  word shifted into stage 0
io_enable  input  1  operation strobe; low = hold everything
io_mode  input  2  00 shift, 01 rotate, 10 parallel load, 11 clear
io_load  input  WIDTH*DEPTH  parallel load data; stage i = io_load[i*WIDTH +: WIDTH]
io_tap_sel  input  SEL_W  stage index for io_tap
io_out  output  WIDTH  stage[DEPTH-1], registered
io_tap  output  WIDTH  stage[io_tap_sel], combinational mux of registers
io_fill  output  CNT_W  number of valid words held
io_full  output  1  io_fill == DEPTH

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-safe deassert): all stages 0, io_fill 0. Resulting outputs: io_out 0, io_tap 0, io_full 0. Reset mid-operation discards all contents immediately.
- All state updates on rising clk only when reset high and io_enable=1. io_enable=0: stages and fill hold; io_mode, io_in and io_load are ignored.
- Shift (00): stage[0]<=io_in; stage[i]<=stage[i-1] for i=1..DEPTH-1. Old stage[DEPTH-1] is discarded. io_fill<=min(io_fill+1, DEPTH), saturating and never wrapping.
- Rotate (01): stage[0]<=stage[DEPTH-1]; others as shift; io_in ignored; io_fill unchanged.
- Load (10): all stages from io_load in one cycle; io_fill<=DEPTH.
- Clear (11): all stages 0; io_fill<=0.
- DEPTH=1: shift makes stage[0]<=io_in. Rotate leaves stage[0] unchanged. io_tap_sel is ignored and stage 0 is always tapped.
- Latency: a word presented with shift at edge k appears on io_out after DEPTH enabled shift edges. Disabled cycles stretch latency and lose no data.
- io_tap_sel >= DEPTH (non-power-of-2 DEPTH): io_tap = 0.
- io_tap reflects registered contents only; there is no bypass of io_in.
- Illegal mode encodings: none; all four are defined.
- No X propagation: every stage is reset and every mode writes a defined value.

Test Plan (WIDTH=8, DEPTH=4 unless stated):
1. Reset low, then high; shift 0x11,0x22,0x33,0x44 on consecutive cycles. Required: io_out 0x00 through the third edge and 0x11 after the fourth edge. io_fill reads 1,2,3,4; io_full=1 after the fourth edge. A fifth shift of 0x55 gives io_out=0x22, io_fill stays 4.
2. Load io_load=0x44332211, then rotate 4 times. Required: io_out sequence 0x44 (after load), 0x33, 0x22, 0x11, 0x44. io_fill is 4 throughout.
3. Shift 0xAA with io_enable toggling 1,0,0,1,1,1. Required: contents hold while io_enable=0. 0xAA reaches io_out only on the fourth enabled edge; io_fill does not change on disabled cycles.
4. After a load, set io_tap_sel=0..3. Required: io_tap = 0x11,0x22,0x33,0x44. For DEPTH=3, io_tap_sel=3 gives io_tap=0x00.
5. Clear while full. Required: all taps 0, io_fill=0, io_full=0 on the next edge. Separately, assert reset low mid-shift, asynchronously between edges: outputs go 0 immediately, before any clk edge.
6. WIDTH=16, DEPTH=1: shift 0xBEEF. Required: io_out=0xBEEF after 1 edge, io_full=1. A rotate leaves io_out at 0xBEEF.
